// File: rtl/ir_nec_tx_if.sv
// Request/status bundle between the control FSM and the NEC IR transmitter.
interface ir_nec_tx_if;
  logic       start;
  logic       repeat_req;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       busy;
  logic       done;
  logic       envelope;
  logic       ir_out;

  modport master (
    output start, repeat_req, addr, cmd,
    input  busy, done, envelope, ir_out
  );

  modport slave (
    input  start, repeat_req, addr, cmd,
    output busy, done, envelope, ir_out
  );
endinterface

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: serialises addr/cmd frames or repeat codes into
// mark/space timing, with marks gated by a carrier that restarts on each mark.
module ir_nec_tx #(
  parameter int UNIT_CYCLES    = 56250,
  parameter int CARRIER_PERIOD = 2632,
  parameter int CARRIER_HIGH   = 877,
  parameter int GUARD_UNITS    = 71
) (
  input  logic       clk,
  input  logic       rst,
  ir_nec_tx_if.slave bus
);

  localparam int MAX_UNITS = (GUARD_UNITS > 16) ? GUARD_UNITS : 16;
  localparam int UW        = ($clog2(MAX_UNITS + 1) > 5) ? $clog2(MAX_UNITS + 1) : 5;
  localparam int UCW       = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int CCW       = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;

  localparam logic [UCW-1:0] UNIT_LAST = UCW'(UNIT_CYCLES - 1);
  localparam logic [CCW-1:0] CARR_LAST = CCW'(CARRIER_PERIOD - 1);
  localparam logic [CCW-1:0] CARR_HIGH = CCW'(CARRIER_HIGH);
  localparam logic [UW-1:0]  U_LEAD_M  = UW'(16);
  localparam logic [UW-1:0]  U_LEAD_S  = UW'(8);
  localparam logic [UW-1:0]  U_RPT_S   = UW'(4);
  localparam logic [UW-1:0]  U_ONE     = UW'(1);
  localparam logic [UW-1:0]  U_THREE   = UW'(3);
  localparam logic [UW-1:0]  U_GUARD   = UW'(GUARD_UNITS);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GUARD
  } state_t;

  state_t          state, state_d;
  logic [UCW-1:0]  unit_cnt, unit_d;
  logic [UW-1:0]   units_left, units_d;
  logic [4:0]      bit_idx, bit_d;
  logic [31:0]     shreg, shreg_d;
  logic [CCW-1:0]  carr_cnt, carr_d;
  logic            rpt, rpt_d;
  logic            done_q, done_d;

  logic            unit_end;
  logic            phase_end;
  logic            mark_now;
  logic            mark_next;

  assign unit_end  = (unit_cnt == UNIT_LAST);
  assign phase_end = unit_end && (units_left == U_ONE);
  assign mark_now  = state inside {LEAD_MARK, BIT_MARK, STOP_MARK};
  assign mark_next = state_d inside {LEAD_MARK, BIT_MARK, STOP_MARK};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      unit_cnt   <= '0;
      units_left <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      carr_cnt   <= '0;
      rpt        <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_d;
      unit_cnt   <= unit_d;
      units_left <= units_d;
      bit_idx    <= bit_d;
      shreg      <= shreg_d;
      carr_cnt   <= carr_d;
      rpt        <= rpt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    unit_d  = unit_cnt;
    units_d = units_left;
    bit_d   = bit_idx;
    shreg_d = shreg;
    rpt_d   = rpt;
    done_d  = 1'b0;

    // Every phase shares one unit timer; per-state code only reloads the
    // unit budget when a phase runs out.
    if (state != IDLE) begin
      unit_d = unit_end ? '0 : unit_cnt + 1'b1;
      if (unit_end && !phase_end) begin
        units_d = units_left - 1'b1;
      end
    end

    unique case (state)
      IDLE: begin
        units_d = '0;
        unit_d  = '0;
        bit_d   = '0;
        if (bus.start) begin
          shreg_d = {~bus.cmd, bus.cmd, ~bus.addr, bus.addr};
          rpt_d   = 1'b0;
          state_d = LEAD_MARK;
          units_d = U_LEAD_M;
        end else if (bus.repeat_req) begin
          rpt_d   = 1'b1;
          state_d = LEAD_MARK;
          units_d = U_LEAD_M;
        end
      end
      LEAD_MARK: if (phase_end) begin
        state_d = LEAD_SPACE;
        units_d = rpt ? U_RPT_S : U_LEAD_S;
      end
      LEAD_SPACE: if (phase_end) begin
        state_d = rpt ? STOP_MARK : BIT_MARK;
        units_d = U_ONE;
        bit_d   = '0;
      end
      BIT_MARK: if (phase_end) begin
        state_d = BIT_SPACE;
        units_d = shreg[0] ? U_THREE : U_ONE;
      end
      BIT_SPACE: if (phase_end) begin
        shreg_d = {1'b0, shreg[31:1]};
        units_d = U_ONE;
        if (bit_idx == 5'd31) begin
          state_d = STOP_MARK;
          bit_d   = '0;
        end else begin
          state_d = BIT_MARK;
          bit_d   = bit_idx + 1'b1;
        end
      end
      STOP_MARK: if (phase_end) begin
        state_d = GUARD;
        units_d = U_GUARD;
      end
      GUARD: if (phase_end) begin
        state_d = IDLE;
        units_d = '0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Marks are never back-to-back, so the carrier phase restarts at 0 on
    // the first cycle of every mark and rests at 0 during spaces.
    if (mark_now && mark_next) begin
      carr_d = (carr_cnt == CARR_LAST) ? '0 : carr_cnt + 1'b1;
    end else begin
      carr_d = '0;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.envelope = mark_now;
  assign bus.ir_out   = mark_now && (carr_cnt < CARR_HIGH);

endmodule

// File: tb/tb_ir_nec_tx.sv
// Scoreboard bench for ir_nec_tx: expected mark/space segments and frame
// lengths are queued at request time and matched by an envelope monitor.
module tb_ir_nec_tx;
  localparam int UC = 12;
  localparam int CP = 3;
  localparam int CH = 1;
  localparam int GU = 4;

  localparam int K_SPACE = 0;
  localparam int K_MARK  = 1;
  localparam int K_FRAME = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ir_nec_tx_if bus ();

  ir_nec_tx #(
    .UNIT_CYCLES   (UC),
    .CARRIER_PERIOD(CP),
    .CARRIER_HIGH  (CH),
    .GUARD_UNITS   (GU)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int val;
  } item_t;

  item_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int val);
    item_t it;
    it.kind = kind;
    it.val  = val;
    exp_q.push_back(it);
  endtask

  task automatic push_frame(input logic [31:0] word);
    push(K_MARK, 16 * UC);
    push(K_SPACE, 8 * UC);
    for (int i = 0; i < 32; i++) begin
      push(K_MARK, UC);
      push(K_SPACE, word[i] ? 3 * UC : UC);
    end
    push(K_MARK, UC);
    push(K_SPACE, GU * UC);
    push(K_FRAME, (121 + GU) * UC);
  endtask

  task automatic push_repeat();
    push(K_MARK, 16 * UC);
    push(K_SPACE, 4 * UC);
    push(K_MARK, UC);
    push(K_SPACE, GU * UC);
    push(K_FRAME, (21 + GU) * UC);
  endtask

  function automatic logic exp_ir(input logic env, input int k);
    return env ? ((k % CP) < CH) : 1'b0;
  endfunction

  // Monitor state
  logic mon_prev_busy = 1'b0;
  logic mon_lvl       = 1'b0;
  logic mon_ok        = 1'b1;
  int   mon_len       = 0;
  int   mon_busy_len  = 0;

  task automatic emit(input int kind, input int val, input logic ok);
    item_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_output actual=kind%0d/%0d required=none", kind, val);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("kind_after_%0d_left", exp_q.size()), kind, e.kind);
      check($sformatf("length_kind%0d", kind), val, e.val);
      if (kind != K_FRAME) check($sformatf("carrier_kind%0d_len%0d", kind, val), ok, 1'b1);
      else check("done_at_frame_end", bus.done, 1'b1);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev_busy = 1'b0;
        continue;
      end
      if (bus.busy) begin
        if (!mon_prev_busy) begin
          mon_busy_len = 1;
          mon_lvl      = bus.envelope;
          mon_len      = 1;
          mon_ok       = (bus.ir_out === exp_ir(bus.envelope, 0));
        end else begin
          mon_busy_len++;
          if (bus.envelope !== mon_lvl) begin
            emit(int'(mon_lvl), mon_len, mon_ok);
            mon_lvl = bus.envelope;
            mon_len = 1;
            mon_ok  = (bus.ir_out === exp_ir(bus.envelope, 0));
          end else begin
            mon_ok  = mon_ok && (bus.ir_out === exp_ir(bus.envelope, mon_len));
            mon_len++;
          end
        end
      end else if (mon_prev_busy) begin
        emit(int'(mon_lvl), mon_len, mon_ok);
        emit(K_FRAME, mon_busy_len, 1'b1);
      end else if (bus.done !== 1'b0 || bus.envelope !== 1'b0 || bus.ir_out !== 1'b0) begin
        check("idle_outputs", {bus.done, bus.envelope, bus.ir_out}, 3'b000);
      end
      mon_prev_busy = bus.busy;
    end
  end

  task automatic pulse(input logic s, input logic r, input logic [7:0] a,
                       input logic [7:0] c, input bit chk);
    bus.start      = s;
    bus.repeat_req = r;
    bus.addr       = a;
    bus.cmd        = c;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.repeat_req = 1'b0;
    if (chk) begin
      check("latency_busy", bus.busy, 1'b1);
      check("latency_envelope", bus.envelope, 1'b1);
      check("latency_ir_out", bus.ir_out, 1'b1);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) check({name, "_done_timeout"}, bus.done, 1'b1);
  endtask

  initial begin
    int   edges;
    int   n;
    logic pe;

    bus.start      = 1'b0;
    bus.repeat_req = 1'b0;
    bus.addr       = '0;
    bus.cmd        = '0;

    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_envelope", bus.envelope, 1'b0);
    check("reset_ir_out", bus.ir_out, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    push_frame(32'h00FFFF00);
    pulse(1'b1, 1'b0, 8'h00, 8'hFF, 1'b1);
    drain("frame_00_ff");

    push_frame(32'hC33CA55A);
    pulse(1'b1, 1'b0, 8'h5A, 8'h3C, 1'b1);
    drain("frame_5a_3c");

    push_repeat();
    pulse(1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    drain("repeat");

    // Second start lands in the leader space and must be dropped; the changed
    // addr/cmd must not leak into the frame in flight.
    push_frame(32'hCB34ED12);
    pulse(1'b1, 1'b0, 8'h12, 8'h34, 1'b1);
    repeat (200) @(negedge clk);
    pulse(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
    drain("ignored_start");

    // Simultaneous requests, then a repeat issued in the done cycle.
    push_frame(32'hF00F5EA1);
    pulse(1'b1, 1'b1, 8'hA1, 8'h0F, 1'b1);
    wait_done("both_requests");
    push_repeat();
    pulse(1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    drain("back_to_back");

    push_frame(32'hC33CA55A);
    pulse(1'b1, 1'b0, 8'h5A, 8'h3C, 1'b1);
    edges = 0;
    n     = 0;
    pe    = bus.envelope;
    while (edges < 11 && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus.envelope && !pe) edges++;
      pe = bus.envelope;
    end
    check("bit10_reached", edges, 11);
    repeat (5) @(negedge clk);
    check("pre_reset_envelope", bus.envelope, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_busy", bus.busy, 1'b0);
    check("async_reset_envelope", bus.envelope, 1'b0);
    check("async_reset_ir_out", bus.ir_out, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_reset_busy", bus.busy, 1'b0);

    push_frame(32'h00FFFF00);
    pulse(1'b1, 1'b0, 8'h00, 8'hFF, 1'b1);
    drain("after_reset");

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
